// File: rtl/uart_d2h_tx.sv
// UART transmitter that serialises 1-4 bytes of a 32-bit word, highest selected byte first.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits of every byte.
module uart_d2h_tx #(
  parameter int CLKS_PER_BIT = 2083,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [31:0] tx_data,
  input  logic [1:0]  tx_len,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] BIT_RELOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic        STOP_RELOAD = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] bitCnt_q, bitCnt_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic        stopCnt_q, stopCnt_d;
  logic [1:0]  byteCnt_q, byteCnt_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic        readyEn_q;
  logic [7:0]  curByte;
  logic        bitEnd;

  // The byte counter doubles as the byte selector, so bytes leave from tx_len down to 0.
  assign curByte = data_q[{byteCnt_q, 3'b000} +: 8];
  assign bitEnd  = (bitCnt_q == 16'd0);

  // readyEn_q keeps tx_ready low until the first clock edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bitCnt_q  <= 16'd0;
      bitIdx_q  <= 3'd0;
      stopCnt_q <= 1'b0;
      byteCnt_q <= 2'd0;
      data_q    <= 32'd0;
      done_q    <= 1'b0;
      readyEn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      bitIdx_q  <= bitIdx_d;
      stopCnt_q <= stopCnt_d;
      byteCnt_q <= byteCnt_d;
      data_q    <= data_d;
      done_q    <= done_d;
      readyEn_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    bitIdx_d  = bitIdx_q;
    stopCnt_d = stopCnt_q;
    byteCnt_d = byteCnt_q;
    data_d    = data_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d   = START;
          bitCnt_d  = BIT_RELOAD;
          data_d    = tx_data;
          byteCnt_d = tx_len;
        end
      end
      START: begin
        if (bitEnd) begin
          state_d  = DATA;
          bitCnt_d = BIT_RELOAD;
          bitIdx_d = 3'd7;
        end else begin
          bitCnt_d = bitCnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bitEnd) begin
          bitCnt_d = BIT_RELOAD;
          if (bitIdx_q == 3'd0) begin
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
            stopCnt_d = STOP_RELOAD;
`endif
          end else begin
            bitIdx_d = bitIdx_q - 3'd1;
          end
        end else begin
          bitCnt_d = bitCnt_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bitEnd) begin
          state_d   = STOP;
          bitCnt_d  = BIT_RELOAD;
          stopCnt_d = STOP_RELOAD;
        end else begin
          bitCnt_d = bitCnt_q - 16'd1;
        end
      end
`endif
      // The next byte's start bit follows the last stop bit directly, with no idle gap.
      STOP: begin
        if (bitEnd) begin
          if (stopCnt_q != 1'b0) begin
            stopCnt_d = stopCnt_q - 1'b1;
            bitCnt_d  = BIT_RELOAD;
          end else if (byteCnt_q != 2'd0) begin
            state_d   = START;
            bitCnt_d  = BIT_RELOAD;
            byteCnt_d = byteCnt_q - 2'd1;
          end else begin
            state_d  = IDLE;
            bitCnt_d = 16'd0;
            done_d   = 1'b1;
          end
        end else begin
          bitCnt_d = bitCnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    case (state_q)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = curByte[bitIdx_q];
`ifdef UART_TX_PARITY_EN
      PARITY:  uart_tx = ^curByte;
`endif
      default: uart_tx = 1'b1;
    endcase
  end

  assign tx_ready = (state_q == IDLE) && readyEn_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_uart_d2h_tx.sv
// Scoreboard bench for uart_d2h_tx: stimulus queues expected bytes and latencies,
// independent monitors decode the serial line and time the done pulse.
module tb_uart_d2h_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PBIT = 1;
`else
  localparam int PBIT = 0;
`endif
  localparam int FRAME = (10 + PBIT) * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [31:0] tx_data = 32'd0;
  logic [1:0]  tx_len = 2'd0;
  logic        uart_tx;
  logic        busy;
  logic        done;

  int checkCount = 0;
  int passCount = 0;
  int cyc = 0;
  int doneCount = 0;
  logic [7:0] expQ[$];
  int expLatQ[$];
  int hsQ[$];
  int hsLog[$];

  uart_d2h_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_len(tx_len), .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic failNote(input string name);
    checkCount++;
    $display("[TB] FAIL %s: got no valid event, expected one (t=%0t)", name, $time);
  endtask

  task automatic pushExpected(input logic [31:0] data, input logic [1:0] len);
    for (int i = int'(len); i >= 0; i--) expQ.push_back(data[i*8 +: 8]);
    expLatQ.push_back((int'(len) + 1) * FRAME);
  endtask

  task automatic waitHs(input int target);
    int t = 0;
    while (hsLog.size() < target && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    if (hsLog.size() < target) failNote("handshakeTimeout");
  endtask

  task automatic waitDone(input int target);
    int t = 0;
    while (doneCount < target && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (doneCount < target) failNote("doneTimeout");
  endtask

  // Sends one word; optionally samples the centre of each of the first ten line bits.
  task automatic applyStimulus(input logic [31:0] data, input logic [1:0] len,
                               input bit checkBits, input logic [9:0] expBits);
    int hsBase = hsLog.size();
    int dBase = doneCount;
    pushExpected(data, len);
    @(posedge clk); #1;
    tx_data = data;
    tx_len = len;
    tx_valid = 1'b1;
    waitHs(hsBase + 1);
    tx_valid = 1'b0;
    checkOutput("busyInFlight", busy, 1);
    checkOutput("readyInFlight", tx_ready, 0);
    if (checkBits) begin
      for (int i = 0; i < 10; i++) begin
        repeat (i == 0 ? 3 : 4) @(negedge clk);
        checkOutput($sformatf("lineBit%0d", i), uart_tx, expBits[9-i]);
      end
    end
    waitDone(dBase + 1);
  endtask

  initial begin : handshakeMonitor
    forever begin
      @(negedge clk);
      if (!rst && tx_valid && tx_ready) begin
        hsQ.push_back(cyc + 1);
        hsLog.push_back(cyc + 1);
      end
    end
  end

  initial begin : doneMonitor
    bit prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevDone = 1'b0;
      end else begin
        if (prevDone) checkOutput("donePulseWidth", done, 0);
        if (done) begin
          doneCount++;
          checkOutput("readyAtDone", tx_ready, 1);
          checkOutput("busyAtDone", busy, 0);
          if (hsQ.size() == 0 || expLatQ.size() == 0) failNote("doneUnexpected");
          else checkOutput("doneLatency", cyc - hsQ.pop_front(), expLatQ.pop_front());
        end
        prevDone = done;
      end
    end
  end

  // Decodes frames at bit centres; a reset seen mid-frame discards the partial byte.
  initial begin : frameMonitor
    logic [7:0] rxByte;
    logic [7:0] expByte;
    logic stopBit;
    logic parBit;
    bit aborted;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        aborted = 1'b0;
        rxByte = 8'd0;
        stopBit = 1'b0;
        parBit = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          rxByte = {rxByte[6:0], uart_tx};
        end
`ifdef UART_TX_PARITY_EN
        if (!aborted) begin
          repeat (4) @(negedge clk);
          if (rst) aborted = 1'b1;
          else parBit = uart_tx;
        end
`endif
        if (!aborted) begin
          repeat (4) @(negedge clk);
          if (rst) aborted = 1'b1;
          else stopBit = uart_tx;
        end
        if (!aborted) begin
          if (expQ.size() == 0) begin
            failNote("unexpectedByte");
          end else begin
            expByte = expQ.pop_front();
            checkOutput("rxByte", rxByte, expByte);
`ifdef UART_TX_PARITY_EN
            checkOutput("rxParity", parBit, ^expByte);
`endif
          end
          checkOutput("stopBit", stopBit, 1);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int hsBase;
    int dBase;
    #2;
    checkOutput("resetLine", uart_tx, 1);
    checkOutput("resetReady", tx_ready, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("readyAfterReset", tx_ready, 1);

    $display("[TB] single byte 0x57");
    applyStimulus(32'h00000057, 2'd0, 1'b1, 10'b0010101111);

    $display("[TB] four bytes 0xDEADBEEF");
    applyStimulus(32'hDEADBEEF, 2'd3, 1'b0, 10'd0);

    $display("[TB] two and three byte words");
    applyStimulus(32'hFFFF1234, 2'd1, 1'b0, 10'd0);
    applyStimulus(32'hFFABCDEF, 2'd2, 1'b0, 10'd0);

    $display("[TB] reset during second byte of 0xDEADBEEF");
    hsBase = hsLog.size();
    dBase = doneCount;
    pushExpected(32'hDEADBEEF, 2'd3);
    @(posedge clk); #1;
    tx_data = 32'hDEADBEEF;
    tx_len = 2'd3;
    tx_valid = 1'b1;
    waitHs(hsBase + 1);
    tx_valid = 1'b0;
    repeat (49) @(posedge clk);
    checkOutput("lineBeforeAbort", uart_tx, 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("abortLine", uart_tx, 1);
    checkOutput("abortReady", tx_ready, 0);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    expQ.delete();
    expLatQ.delete();
    hsQ.delete();
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("readyBeforeFirstEdge", tx_ready, 0);
    @(posedge clk); #1;
    checkOutput("readyAfterAbort", tx_ready, 1);
    checkOutput("noDoneAfterAbort", doneCount, dBase);
    applyStimulus(32'h000000A5, 2'd0, 1'b1, 10'b0101001011);

    $display("[TB] tx_valid held through 0x11 then 0x22");
    hsBase = hsLog.size();
    dBase = doneCount;
    pushExpected(32'h00000011, 2'd0);
    pushExpected(32'h00000022, 2'd0);
    @(posedge clk); #1;
    tx_data = 32'h00000011;
    tx_len = 2'd0;
    tx_valid = 1'b1;
    waitHs(hsBase + 1);
    tx_data = 32'h00000022;
    waitHs(hsBase + 2);
    tx_valid = 1'b0;
    waitDone(dBase + 2);
    if (hsLog.size() >= hsBase + 2)
      checkOutput("backToBackGap", hsLog[hsBase+1] - hsLog[hsBase], FRAME + 1);
    else
      failNote("backToBackGap");

    repeat (10) @(posedge clk);
    checkOutput("expQueueDrained", expQ.size(), 0);
    checkOutput("latQueueDrained", expLatQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
